// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader sitting in front of the processor. It accepts a program
//   image as a stream of words (length N, N instruction words, checksum),
//   writes the instruction words into instruction memory starting at
//   base_addr, and keeps the processor in reset until the image checksum
//   verifies.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   start          one-cycle load request (honoured in IDLE, DONE, ERROR)
//   base_addr      first instruction-memory address, sampled on start
//   s_valid/s_data upstream word stream
//   s_ready        registered; high in LEN, DATA, CSUM
//   mem_we/mem_addr/mem_wdata  instruction-memory write port (1-cycle pulses)
//   cpu_reset      processor reset, low only in DONE
//   busy/done/error  status flags
//   words_written  data words written in the current load
module program_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_W-1:0]      length;
    logic [DATA_WIDTH-1:0] checksum;
    logic                  beat;
    logic                  start_ok;
    logic                  len_too_big;
    logic                  last_data;

    assign beat        = s_valid & s_ready;
    assign start_ok    = start & (state inside {ST_IDLE, ST_DONE, ST_ERROR});
    // An image may fill the whole memory, so N == 2^ADDR_WIDTH is still legal.
    assign len_too_big = 32'(s_data) > (32'd1 << ADDR_WIDTH);
    assign last_data   = (words_written + LEN_W'(1)) == length;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) next_state = ST_LEN;
            end
            ST_LEN: begin
                if (beat) begin
                    if (len_too_big)        next_state = ST_ERROR;
                    else if (s_data == '0)  next_state = ST_CSUM;
                    else                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat && last_data) next_state = ST_CSUM;
            end
            ST_CSUM: begin
                if (beat) next_state = (s_data == checksum) ? ST_DONE : ST_ERROR;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            s_ready       <= 1'b0;
            cpu_reset     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            words_written <= '0;
            addr          <= '0;
            length        <= '0;
            checksum      <= '0;
        end else begin
            state     <= next_state;
            s_ready   <= next_state inside {ST_LEN, ST_DATA, ST_CSUM};
            busy      <= next_state inside {ST_LEN, ST_DATA, ST_CSUM};
            cpu_reset <= next_state != ST_DONE;
            done      <= next_state == ST_DONE;
            error     <= next_state == ST_ERROR;
            mem_we    <= 1'b0;

            if (start_ok) begin
                addr          <= base_addr;
                checksum      <= '0;
                words_written <= '0;
                length        <= '0;
            end

            if (state == ST_LEN && beat) begin
                length <= LEN_W'(s_data);
            end

            if (state == ST_DATA && beat) begin
                mem_we        <= 1'b1;
                mem_addr      <= addr;
                mem_wdata     <= s_data;
                addr          <= addr + ADDR_WIDTH'(1);
                checksum      <= checksum + s_data;
                words_written <= words_written + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed-vector bench for program_loader (ADDR_WIDTH=12, DATA_WIDTH=16).
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] words_written;

    program_loader #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_reset     (cpu_reset),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t wr_q[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_q.push_back('{mem_addr, mem_wdata, cyc});
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [11:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    // Offer one word and return 1 time unit after the edge it transferred on.
    task automatic send(input logic [15:0] d);
        int t;
        t       = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (s_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (s_ready !== 1'b1) check("send_timeout", 32'(s_ready), 32'd1);
        tick();
    endtask

    task automatic idle();
        s_valid = 1'b0;
        tick();
    endtask

    // gap = expected cycle distance from the previous write, 0 to skip.
    task automatic check_wr(input int i, input logic [11:0] a, input logic [15:0] d, input int gap);
        if (i >= wr_q.size()) begin
            check($sformatf("wr%0d_present", i), 32'(wr_q.size()), 32'(i + 1));
        end else begin
            check($sformatf("wr%0d_addr", i), 32'(wr_q[i].addr), 32'(a));
            check($sformatf("wr%0d_data", i), 32'(wr_q[i].data), 32'(d));
            if (gap != 0 && i > 0)
                check($sformatf("wr%0d_gap", i), 32'(wr_q[i].cyc - wr_q[i-1].cyc), 32'(gap));
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        start   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        do_reset();

        // Reset state
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_ww", 32'(words_written), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);

        // 1: basic load, back-to-back
        wr_q.delete();
        start_load(12'h010);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_s_ready", 32'(s_ready), 32'd1);
        send(16'd3);
        send(16'h1111);
        send(16'h2222);
        send(16'h3333);
        send(16'h6666);
        s_valid = 1'b0;
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_ww", 32'(words_written), 32'd3);
        check("t1_nwr", 32'(wr_q.size()), 32'd3);
        check_wr(0, 12'h010, 16'h1111, 0);
        check_wr(1, 12'h011, 16'h2222, 1);
        check_wr(2, 12'h012, 16'h3333, 1);
        tick();
        check("t1_done_hold", 32'(done), 32'd1);
        check("t1_mem_we_idle", 32'(mem_we), 32'd0);

        // 6b (from DONE): start restarts the load
        start_load(12'h010);
        check("t6_done_start_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t6_done_start_ww", 32'(words_written), 32'd0);
        check("t6_done_start_busy", 32'(busy), 32'd1);
        check("t6_done_start_ready", 32'(s_ready), 32'd1);

        // 2: bad checksum
        wr_q.delete();
        send(16'd3);
        send(16'h1111);
        send(16'h2222);
        send(16'h3333);
        send(16'h6667);
        s_valid = 1'b0;
        check("t2_error", 32'(error), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        check("t2_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t2_ww", 32'(words_written), 32'd3);
        tick();
        tick();
        check("t2_nwr", 32'(wr_q.size()), 32'd3);
        check("t2_s_ready", 32'(s_ready), 32'd0);
        check("t2_error_hold", 32'(error), 32'd1);

        // 3a: empty image
        wr_q.delete();
        start_load(12'h100);
        send(16'd0);
        send(16'h0000);
        s_valid = 1'b0;
        tick();
        check("t3_empty_done", 32'(done), 32'd1);
        check("t3_empty_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t3_empty_nwr", 32'(wr_q.size()), 32'd0);

        // 3b: oversize length
        start_load(12'h100);
        send(16'h1001);
        s_valid = 1'b0;
        check("t3_big_error", 32'(error), 32'd1);
        check("t3_big_busy", 32'(busy), 32'd0);
        check("t3_big_ready", 32'(s_ready), 32'd0);
        check("t3_big_ww", 32'(words_written), 32'd0);

        // 3c: maximum legal length fills the whole memory
        wr_q.delete();
        start_load(12'h000);
        send(16'h1000);
        for (int i = 0; i < 4096; i++) send(16'h0001);
        send(16'h1000);
        s_valid = 1'b0;
        check("t3_max_done", 32'(done), 32'd1);
        check("t3_max_ww", 32'(words_written), 32'h1000);
        check("t3_max_nwr", 32'(wr_q.size()), 32'd4096);
        check_wr(4095, 12'hFFF, 16'h0001, 1);

        // 4a: address wrap
        wr_q.delete();
        start_load(12'hFFE);
        send(16'd4);
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        send(16'hFFFC);
        s_valid = 1'b0;
        check("t4_done", 32'(done), 32'd1);
        check("t4_ww", 32'(words_written), 32'd4);
        check_wr(0, 12'hFFE, 16'hFFFF, 0);
        check_wr(1, 12'hFFF, 16'hFFFF, 1);
        check_wr(2, 12'h000, 16'hFFFF, 1);
        check_wr(3, 12'h001, 16'hFFFF, 1);

        // 4b: same with s_valid toggling
        wr_q.delete();
        start_load(12'hFFE);
        send(16'd4);
        idle();
        for (int i = 0; i < 4; i++) begin
            send(16'hFFFF);
            idle();
        end
        send(16'hFFFC);
        s_valid = 1'b0;
        check("t4bp_done", 32'(done), 32'd1);
        check("t4bp_ww", 32'(words_written), 32'd4);
        check("t4bp_nwr", 32'(wr_q.size()), 32'd4);
        check_wr(0, 12'hFFE, 16'hFFFF, 0);
        check_wr(1, 12'hFFF, 16'hFFFF, 2);
        check_wr(2, 12'h000, 16'hFFFF, 2);
        check_wr(3, 12'h001, 16'hFFFF, 2);

        // 5: reset mid-load
        start_load(12'h020);
        send(16'd5);
        send(16'h0001);
        send(16'h0002);
        s_valid = 1'b0;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        check("t5_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ww", 32'(words_written), 32'd0);
        check("t5_ready", 32'(s_ready), 32'd0);
        check("t5_mem_we", 32'(mem_we), 32'd0);
        wr_q.delete();
        start_load(12'h020);
        send(16'd5);
        send(16'h0010);
        send(16'h0020);
        send(16'h0030);
        send(16'h0040);
        send(16'h0050);
        send(16'h00F0);
        s_valid = 1'b0;
        check("t5_reload_done", 32'(done), 32'd1);
        check("t5_reload_ww", 32'(words_written), 32'd5);
        check_wr(0, 12'h020, 16'h0010, 0);
        check_wr(4, 12'h024, 16'h0050, 1);

        // 6a: start while in DATA is ignored
        wr_q.delete();
        start_load(12'h040);
        send(16'd4);
        send(16'h0101);
        send(16'h0202);
        s_valid = 1'b0;
        start_load(12'h300);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_ww", 32'(words_written), 32'd2);
        send(16'h0303);
        send(16'h0404);
        send(16'h0A0A);
        s_valid = 1'b0;
        check("t6_done", 32'(done), 32'd1);
        check("t6_ww_final", 32'(words_written), 32'd4);
        check_wr(0, 12'h040, 16'h0101, 0);
        check_wr(1, 12'h041, 16'h0202, 0);
        check_wr(2, 12'h042, 16'h0303, 0);
        check_wr(3, 12'h043, 16'h0404, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time block upstream of the processor. It receives a program image as a stream of 16-bit words and writes it into the instruction memory write port.
- It holds the processor in reset until the whole image is written and its checksum verifies.
- Output `cpu_reset` drives the processor `reset` input.
- The image format is: one length word N, then N instruction words, then one checksum word.

Parameters:
ADDR_WIDTH, 12, instruction-memory word-address width; max image size 2^ADDR_WIDTH words
DATA_WIDTH, 16, instruction word width

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load, honoured only in IDLE, DONE or ERROR
base_addr  input  ADDR_WIDTH  first instruction-memory address; sampled on accepted start
s_valid  input  1  upstream word valid
s_data  input  DATA_WIDTH  upstream word
s_ready  output  1  loader can accept a word this cycle
mem_we  output  1  instruction-memory write enable
mem_addr  output  ADDR_WIDTH  write address
mem_wdata  output  DATA_WIDTH  write data
cpu_reset  output  1  processor reset; high except in DONE
busy  output  1  high in LEN, DATA or CSUM
done  output  1  high in DONE
error  output  1  high in ERROR
words_written  output  ADDR_WIDTH+1  count of data words written in the current load

Behaviour:
- Beat: a word transfers on any clk edge where s_valid=1 and s_ready=1. s_data is ignored in every other cycle.
- s_ready=1 only in LEN, DATA and CSUM. It is registered and has no combinational path from s_valid.
- Reset (any state, including mid-load) forces:
  - state=IDLE
  - cpu_reset=1, mem_we=0, mem_addr=0, mem_wdata=0
  - busy=0, done=0, error=0, words_written=0
  - internal length=0, checksum=0
- States:
  - IDLE: cpu_reset=1. start moves to LEN and latches base_addr into the address counter.
  - LEN: a beat latches N = s_data.
    - N > 2^ADDR_WIDTH -> ERROR.
    - N = 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: each beat does the following.
    - One cycle after the beat: mem_we=1, mem_addr = current address, mem_wdata = s_data.
    - Address counter increments modulo 2^ADDR_WIDTH, so wrap past the top address to 0 is legal.
    - checksum <= checksum + s_data, truncated to DATA_WIDTH.
    - words_written increments.
    - After the Nth beat -> CSUM.
  - CSUM: a beat compares s_data with the running checksum. Equal -> DONE; otherwise -> ERROR. No memory write.
  - DONE: cpu_reset=0 and done=1; the processor runs.
  - ERROR: error=1 and cpu_reset=1. It stays here until start or reset.
- start in DONE or ERROR behaves like start in IDLE: it returns to LEN and clears checksum and words_written.
  - In DONE, the cycle start is accepted raises cpu_reset=1 on the next edge.
- start while busy is ignored.
- mem_we is a registered single-cycle pulse per data beat.
  - Back-to-back beats give consecutive mem_we cycles with consecutive addresses.
  - mem_we is 0 in every other cycle.
- words_written and the checksum hold their final values in DONE and ERROR.
- Latency: from the last (checksum) beat to cpu_reset falling is exactly 1 clk.

Test Plan:
1. Reset → start, base_addr=0x010 → stream 3, 0x1111, 0x2222, 0x3333, 0x6666 with s_valid held high → mem writes (0x010,0x1111), (0x011,0x2222), (0x012,0x3333) on 3 consecutive cycles; done=1, cpu_reset=0 one cycle after the checksum beat; words_written=3.
2. Same image with checksum 0x6667 → no extra writes; error=1, cpu_reset stays 1; s_ready=0 afterwards until start.
3. N=0, checksum 0x0000 → DONE with mem_we never asserted. N=0x1001 with ADDR_WIDTH=12 → ERROR directly after the length beat.
4. Wrap and backpressure:
   - base_addr=0xFFE, N=4, words 0xFFFF×4, checksum 0xFFFC → writes at 0xFFE, 0xFFF, 0x000, 0x001; DONE.
   - Repeat with s_valid toggling every other cycle → identical writes, spaced apart, same final state.
5. Reset asserted after 2 of 5 data beats → next cycle IDLE, cpu_reset=1, busy=0, words_written=0; a subsequent full load succeeds.
6. Start pulsed while in DATA → ignored, address and count unaffected. Start pulsed in DONE → cpu_reset=1 next cycle, state LEN, words_written=0.
